// File: rtl/fb_pkg.sv
// Shared filterbank definitions: default sizes, the sample type and tap-index helpers.
package fb_pkg;

  localparam int DATA_W_DEF     = 15;
  localparam int DEPTH_DEF      = 119;
  localparam int DECIM_DEF      = 60;
  localparam int CENTRE_IDX_DEF = (DEPTH_DEF - 1) / 2;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  // Number of distinct symmetric pairs, counting an odd centre tap as one.
  function automatic int sym_limit(input int depth);
    return (depth + 1) / 2;
  endfunction

endpackage

// File: rtl/decim_phase_gen.sv
// Decimation phase counter with the shift strobe and the registered new-sample pulse,
// advanced by a clock enable rather than a gated clock.
module decim_phase_gen
  import fb_pkg::*;
#(
  parameter int DECIM = DECIM_DEF,
  parameter int PW    = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clk_enable,
  output logic [PW-1:0] phase_cnt,
  output logic          phase_last,
  output logic          new_sample
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);
  localparam logic [PW-1:0] ONE        = PW'(1);

  logic [PW-1:0] phase_cnt_r;
  logic          new_sample_r;

  // Strobe is combinational so the history shifts on the same edge that wraps the counter.
  assign phase_last = clk_enable && (phase_cnt_r == LAST_PHASE);
  assign phase_cnt  = phase_cnt_r;
  assign new_sample = new_sample_r;

  // Phase counter wraps on the strobe and holds while the enable is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_cnt_r  <= '0;
      new_sample_r <= 1'b0;
    end else begin
      new_sample_r <= phase_last;
      if (phase_last) begin
        phase_cnt_r <= '0;
      end else if (clk_enable) begin
        phase_cnt_r <= phase_cnt_r + ONE;
      end else begin
        phase_cnt_r <= phase_cnt_r;
      end
    end
  end

endmodule

// File: rtl/decim_delay_line.sv
// Decimated sample-history register: parallel taps for the per-band filters plus a
// one-cycle random-access read port with optional symmetric pre-add for serial MACs.
module decim_delay_line
  import fb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DECIM  = DECIM_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clk_enable,
  input  logic signed [DATA_W-1:0]  filter_in,
  output logic                      phase_last,
  output logic [$clog2(DECIM)-1:0]  phase_cnt,
  output logic [DEPTH*DATA_W-1:0]   taps,
  output logic                      new_sample,
  output logic                      primed,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  input  logic                      sym_mode,
  output logic                      rd_valid,
  output logic signed [DATA_W:0]    rd_data,
  output logic                      rd_err
);

  localparam int              PW        = $clog2(DECIM);
  localparam int              FW        = $clog2(DEPTH + 1);
  localparam int              AW1       = AW + 1;
  localparam int              CENTRE    = (DEPTH - 1) / 2;
  localparam bit              ODD_DEPTH = (DEPTH % 2) == 1;
  localparam logic [FW-1:0]   FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0]   FILL_ONE  = FW'(1);
  localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   CENTRE_A  = AW'(CENTRE);
  localparam logic [AW1-1:0]  DEPTH_LIM = AW1'(DEPTH);
  localparam logic [AW1-1:0]  SYM_LIM   = AW1'(sym_limit(DEPTH));

  logic signed [DATA_W-1:0] tap_r [DEPTH];
  logic [FW-1:0]            fill_r;
  logic                     primed_r;
  logic                     rd_valid_r;
  logic signed [DATA_W:0]   rd_data_r;
  logic                     rd_err_r;
  logic                     rd_legal_s;
  logic [AW-1:0]            mirror_s;
  logic signed [DATA_W:0]   rd_result_s;

  function automatic logic signed [DATA_W:0] sext(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  decim_phase_gen #(.DECIM(DECIM), .PW(PW)) u_phase (
    .clock      (clock),
    .reset      (reset),
    .clk_enable (clk_enable),
    .phase_cnt  (phase_cnt),
    .phase_last (phase_last),
    .new_sample (new_sample)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*DATA_W +: DATA_W] = tap_r[g];
  end

  assign primed   = primed_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_err   = rd_err_r;

  // History shift on the phase strobe; the oldest tap falls off the end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) tap_r[k] <= '0;
    end else if (phase_last) begin
      tap_r[0] <= filter_in;
      for (int k = 1; k < DEPTH; k++) tap_r[k] <= tap_r[k-1];
    end
  end

  // Saturating shift count; primed sets on the edge of the DEPTH-th shift so it
  // rises together with that shift's new_sample pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_r   <= '0;
      primed_r <= 1'b0;
    end else if (phase_last && (fill_r != FILL_FULL)) begin
      fill_r <= fill_r + FILL_ONE;
      if (fill_r == (FILL_FULL - FILL_ONE)) begin
        primed_r <= 1'b1;
      end
    end
  end

  // Read mux: range check, then plain or symmetric pre-add at full precision.
  always_comb begin
    mirror_s    = LAST_IDX - rd_addr;
    rd_legal_s  = 1'b0;
    rd_result_s = '0;
    if (sym_mode) begin
      rd_legal_s = {1'b0, rd_addr} < SYM_LIM;
    end else begin
      rd_legal_s = {1'b0, rd_addr} < DEPTH_LIM;
    end
    if (!rd_legal_s) begin
      rd_result_s = '0;
    end else if (sym_mode && ODD_DEPTH && (rd_addr == CENTRE_A)) begin
      rd_result_s = sext(tap_r[rd_addr]);
    end else if (sym_mode) begin
      rd_result_s = sext(tap_r[rd_addr]) + sext(tap_r[mirror_s]);
    end else begin
      rd_result_s = sext(tap_r[rd_addr]);
    end
  end

  // Read result register; data holds between reads, valid and error are single pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_err_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      rd_err_r   <= rd_en && !rd_legal_s;
      if (rd_en) begin
        rd_data_r <= rd_result_s;
      end
    end
  end

endmodule

// File: doc/decim_delay_line.md
Name: decim_delay_line

Overview:
- Parametrised successor to the filterbank sample-history register for the non-uniform filterbank.
- Generates the decimation phase strobe internally and shifts on a clock enable, not on a gated clock.
- Exposes every tap in parallel for the per-band filters.
- Adds a one-cycle-latency random-access read port with an optional symmetric pre-add, for serial MAC filters that use linear-phase coefficients.

Parameters:
- DATA_W, 15, sample width (signed; sfix15_En14 at default)
- DEPTH, 119, number of history taps (>=2)
- DECIM, 60, input clocks per decimated sample (>=2)
- AW, $clog2(DEPTH), read-address width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_enable  in  1  global advance enable
- filter_in  in  DATA_W  signed input sample
- phase_last  out  1  high while phase_cnt==DECIM-1 and clk_enable==1 (shift cycle)
- phase_cnt  out  $clog2(DECIM)  current decimation phase
- taps  out  DEPTH*DATA_W  flattened history; tap k occupies bits [k*DATA_W +: DATA_W]; tap 0 is newest
- new_sample  out  1  one-cycle pulse on the cycle after a shift
- primed  out  1  high once DEPTH shifts have occurred since reset
- rd_en  in  1  read request
- rd_addr  in  AW  tap index
- sym_mode  in  1  0 returns tap[rd_addr]; 1 returns tap[rd_addr]+tap[DEPTH-1-rd_addr]
- rd_valid  out  1  read data valid
- rd_data  out  DATA_W+1  signed, sign-extended read result
- rd_err  out  1  pulse: address out of range

Behaviour:
- Reset (asynchronous, active-low), all state and outputs clear:
  - phase_cnt=0 and every tap=0
  - new_sample, primed, rd_valid, rd_data and rd_err all 0
  - fill counter cleared
- Phase counter:
  - Counts only when clk_enable=1.
  - Counts 0..DECIM-1, then wraps to 0.
  - Holds when clk_enable=0; phase_last is 0 while enable is low.
- Shift:
  - Happens on the edge where phase_last=1.
  - tap[k] <= tap[k-1] for k=1..DEPTH-1; tap[0] <= filter_in.
  - tap[DEPTH-1] is discarded.
- new_sample is registered phase_last, so it is high for exactly 1 cycle per shift.
- Fill counter:
  - Saturating, counts shifts.
  - primed rises on the cycle new_sample is asserted for the DEPTH-th shift.
  - primed stays high until reset.
- Read port:
  - Registered with latency 1: rd_en at edge N gives rd_valid and rd_data valid after edge N, held for that one cycle.
  - rd_valid=0 otherwise; rd_data holds its last value when rd_valid=0.
  - A read issued on a shift edge returns the pre-shift contents.
  - Back-to-back reads are supported every cycle, with no stall.
  - The read port is independent of clk_enable.
- Range check:
  - Legal rd_addr is < DEPTH when sym_mode=0, and < ceil(DEPTH/2) when sym_mode=1.
  - Out-of-range read: rd_valid=1, rd_data=0, rd_err=1 for that cycle.
- Symmetric read:
  - Full-precision DATA_W+1 signed sum, so it cannot overflow.
  - When DEPTH is odd and rd_addr=(DEPTH-1)/2, the result is the single centre tap, sign-extended and not doubled.
- Non-symmetric read: the tap value is sign-extended to DATA_W+1.
- Reset asserted mid-operation: all state clears immediately; a pending read result is dropped (rd_valid=0).

Decomposition:
- Shared package `fb_pkg` holds:
  - the DATA_W/DEPTH/DECIM defaults and the sample typedef;
  - the localparam for centre index (DEPTH-1)/2;
  - the function `sym_limit(DEPTH)` = ceil(DEPTH/2).
- One sub-module: `decim_phase_gen`, containing the phase counter plus the phase_last and new_sample logic.
  - Other filterbank blocks reuse it in place of the shared phase strobe from filter1.
- Tap storage and the read mux stay in the top module.

Test Plan:
- Reset, then clk_enable=1 for 59 clocks -> phase_cnt=59 and phase_last=1; next edge shifts in filter_in and phase_cnt=0; new_sample pulses once.
- Feed samples 1,2,3,... one per decimation period for 119 periods -> primed rises with new_sample at the 119th shift; tap0=119 and tap118=1.
- clk_enable toggled low for 10 cycles at phase 30 -> phase_cnt holds at 30, no shift occurs, and the period stretches to 70 clocks.
- With taps 0..118 holding values 100..218:
  - rd_addr=5, sym_mode=0 -> rd_data=105 one cycle later.
  - sym_mode=1, rd_addr=5 -> 105+213=318.
  - sym_mode=1, rd_addr=59 -> 159 (not doubled).
- With tap0=tap118=-16384: sym_mode=1, rd_addr=0 -> -32768 with no wrap. Then rd_addr=60 in sym mode, and rd_addr=119 in normal mode -> rd_err=1 and rd_data=0 for each.
- Reset asserted low mid-read and mid-fill -> rd_valid=0 and primed=0 immediately; after release, taps are all 0 and the phase restarts at 0.
